multi_digit_counter: RTL and testbench



---
 rtl/multi_digit_counter_pkg.sv | 26 ++
 rtl/multi_digit_counter_hex7seg_decode.sv | 34 +++
 rtl/multi_digit_counter.sv | 104 ++++++++++
 tb/tb_multi_digit_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared constants for the multi-digit counter: widths and active-low
// 7-segment glyphs (bit0 = a .. bit6 = g).
package multi_digit_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/multi_digit_counter_hex7seg_decode.sv
// One-digit hex to active-low 7-segment decoder with a blanking input.
module hex7seg_decode
  import multi_digit_counter_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'h0: seg = SEG_0;
        4'h1: seg = SEG_1;
        4'h2: seg = SEG_2;
        4'h3: seg = SEG_3;
        4'h4: seg = SEG_4;
        4'h5: seg = SEG_5;
        4'h6: seg = SEG_6;
        4'h7: seg = SEG_7;
        4'h8: seg = SEG_8;
        4'h9: seg = SEG_9;
        4'hA: seg = SEG_A;
        4'hB: seg = SEG_B;
        4'hC: seg = SEG_C;
        4'hD: seg = SEG_D;
        4'hE: seg = SEG_E;
        default: seg = SEG_F;
      endcase
    end
  end

endmodule

// File: rtl/multi_digit_counter.sv
// Multi-digit hex/BCD up/down counter with 7-segment outputs.
// Define MULTI_DIGIT_COUNTER_LZB_EN for leading-zero blanking.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BCD        = 0,
  parameter int WRAP       = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          tc,
  output logic [SEG_W*NUM_DIGITS-1:0]   hex
);

  localparam int W = DIGIT_W * NUM_DIGITS;
  localparam logic [3:0] DMAX = (BCD != 0) ? 4'd9 : 4'hF;

  logic [W-1:0]          nxt;
  logic [W-1:0]          lv;
  logic                  term;
  logic [NUM_DIGITS-1:0] blank;

  // Per-digit ripple; carry out of the top digit means count was terminal.
  always_comb begin
    logic [3:0] d;
    logic       c;
    nxt = count;
    c   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == DMAX) begin
            nxt[4*i +: 4] = 4'd0;
          end else begin
            nxt[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nxt[4*i +: 4] = DMAX;
          end else begin
            nxt[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    term = c;
  end

  always_comb begin
    lv = load_val;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (BCD != 0 && load_val[4*i +: 4] > 4'd9)
        lv[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= lv;
      tc    <= 1'b0;
    end else if (en) begin
      tc <= term;
      if (!term || WRAP != 0)
        count <= nxt;
    end else begin
      tc <= 1'b0;
    end
  end

`ifdef MULTI_DIGIT_COUNTER_LZB_EN
  always_comb begin
    logic lit;
    lit   = 1'b0;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lit = lit | (count[4*i +: 4] != 4'd0);
      blank[i] = !lit;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex7seg_decode u_dec (
      .digit (count[4*g +: 4]),
      .blank (blank[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench: hex/wrap, BCD/wrap and hex/saturate instances
// share one stimulus stream.
module tb_multi_digit_counter;
  import multi_digit_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en, up, load;
  logic [15:0] load_val;
  logic [15:0] cnt_h, cnt_b, cnt_s;
  logic        tc_h, tc_b, tc_s;
  logic [27:0] hex_h, hex_b, hex_s;
  int          n_pass = 0;
  int          n_tot  = 0;

  always #5 clk = ~clk;

  multi_digit_counter #(.NUM_DIGITS(4), .BCD(0), .WRAP(1)) u_hex (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt_h), .tc(tc_h), .hex(hex_h));

  multi_digit_counter #(.NUM_DIGITS(4), .BCD(1), .WRAP(1)) u_bcd (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt_b), .tc(tc_b), .hex(hex_b));

  multi_digit_counter #(.NUM_DIGITS(4), .BCD(0), .WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(cnt_s), .tc(tc_s), .hex(hex_s));

`ifdef MULTI_DIGIT_COUNTER_LZB_EN
  localparam logic [27:0] HEX_ZERO = {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
  localparam logic [27:0] HEX_0099 = {SEG_BLANK, SEG_BLANK, SEG_9, SEG_9};
  localparam logic [27:0] HEX_0040 = {SEG_BLANK, SEG_BLANK, SEG_4, SEG_0};
`else
  localparam logic [27:0] HEX_ZERO = {SEG_0, SEG_0, SEG_0, SEG_0};
  localparam logic [27:0] HEX_0099 = {SEG_0, SEG_0, SEG_9, SEG_9};
  localparam logic [27:0] HEX_0040 = {SEG_0, SEG_0, SEG_4, SEG_0};
`endif
  localparam logic [27:0] HEX_ABCD = {SEG_A, SEG_B, SEG_C, SEG_D};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    step(); step();
    check("rst_cnt_h", 32'(cnt_h), 32'h0);
    check("rst_cnt_b", 32'(cnt_b), 32'h0);
    check("rst_cnt_s", 32'(cnt_s), 32'h0);
    check("rst_tc", 32'({tc_h, tc_b, tc_s}), 32'h0);
    check("rst_hex_h", 32'(hex_h), 32'(HEX_ZERO));
    check("rst_hex_b", 32'(hex_b), 32'(HEX_ZERO));

    reset = 1'b0; en = 1'b0; load = 1'b1; load_val = 16'hFFFE;
    step();
    check("ld_fffe", 32'(cnt_h), 32'hFFFE);
    check("ld_tc", 32'(tc_h), 32'h0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check("up_ffff", 32'(cnt_h), 32'hFFFF);
    check("up_ffff_tc", 32'(tc_h), 32'h0);
    step();
    check("wrap_0", 32'(cnt_h), 32'h0);
    check("wrap_tc", 32'(tc_h), 32'h1);
    check("wrap_hex", 32'(hex_h), 32'(HEX_ZERO));
    check("sat_hold_max", 32'(cnt_s), 32'hFFFF);
    check("sat_tc_up", 32'(tc_s), 32'h1);
    en = 1'b0;
    step();
    check("idle_tc", 32'(tc_h), 32'h0);
    check("idle_cnt", 32'(cnt_h), 32'h0);

    load = 1'b1; load_val = 16'h0199;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    check("bcd_carry", 32'(cnt_b), 32'h0200);
    check("bcd_carry_tc", 32'(tc_b), 32'h0);
    check("hex_019a", 32'(cnt_h), 32'h019A);

    en = 1'b0; load = 1'b1; load_val = 16'h00AF;
    step();
    check("bcd_clamp", 32'(cnt_b), 32'h0099);
    check("hex_noclamp", 32'(cnt_h), 32'h00AF);
    check("bcd_hex", 32'(hex_b), 32'(HEX_0099));

    load_val = 16'h0000;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    check("bcd_borrow", 32'(cnt_b), 32'h9999);
    check("bcd_borrow_tc", 32'(tc_b), 32'h1);
    check("hex_borrow", 32'(cnt_h), 32'hFFFF);
    check("sat0_cnt1", 32'(cnt_s), 32'h0);
    check("sat0_tc1", 32'(tc_s), 32'h1);
    for (int i = 0; i < 2; i++) begin
      step();
      check("sat0_cnt", 32'(cnt_s), 32'h0);
      check("sat0_tc", 32'(tc_s), 32'h1);
    end
    check("bcd_9997", 32'(cnt_b), 32'h9997);
    check("bcd_9997_tc", 32'(tc_b), 32'h0);
    check("hex_fffd", 32'(cnt_h), 32'hFFFD);

    load = 1'b1; load_val = 16'h1234; up = 1'b1;
    step();
    check("prio_ld", 32'(cnt_h), 32'h1234);
    check("prio_ld_s", 32'(cnt_s), 32'h1234);
    check("prio_ld_tc", 32'(tc_s), 32'h0);
    reset = 1'b1;
    step();
    check("prio_rst", 32'(cnt_h), 32'h0);
    check("prio_rst_b", 32'(cnt_b), 32'h0);
    reset = 1'b0; en = 1'b0;
    load_val = 16'h0040;
    step();
    check("lzb_0040", 32'(hex_h), 32'(HEX_0040));
    load_val = 16'hABCD;
    step();
    check("glyph_abcd", 32'(hex_h), 32'(HEX_ABCD));
    check("bcd_clamp_all", 32'(cnt_b), 32'h9999);
    load = 1'b0;
    step();
    check("hold", 32'(cnt_h), 32'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
